// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter with alternating priority and a wait-state timeout.
// The current owner's bus is mirrored to the slave, and a stalled slave is terminated with a bus error.
module wb_arbiter_2m #(
    parameter int unsigned ADR_W   = 8,
    parameter int unsigned DAT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic [DAT_W-1:0] m_dat_o,
    output logic             m_err_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic [4:0] TO_CNT = 5'(TIMEOUT);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;        // 1: m1 preferred on a simultaneous request
    logic [4:0] cnt_q, cnt_d;

    logic             own_cyc, own_stb, own_we;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;
    logic             timeout;

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        unique case (state_q)
            OWN0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
            end
            OWN1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign timeout = own_stb && (cnt_q == TO_CNT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = ptr_q ? OWN1 : OWN0;
                else if (m0_cyc_i)        state_d = OWN0;
                else if (m1_cyc_i)        state_d = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    ptr_d   = 1'b1;
                    state_d = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    ptr_d   = 1'b0;
                    state_d = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Any handover, ack, idle strobe or timeout restarts the wait count.
        if ((state_d == state_q) && own_stb && !s_ack_i && !timeout) cnt_d = cnt_q + 5'd1;
        else                                                          cnt_d = '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o    = state_q;
    assign s_cyc_o  = own_cyc;
    assign s_stb_o  = own_stb && !timeout;
    assign s_we_o   = own_we;
    assign s_adr_o  = own_adr;
    assign s_dat_o  = own_dat;
    assign m0_ack_o = (state_q == OWN0) && m0_stb_i && (s_ack_i || timeout);
    assign m1_ack_o = (state_q == OWN1) && m1_stb_i && (s_ack_i || timeout);
    assign m_err_o  = timeout;
    assign m_dat_o  = timeout ? '1 : s_dat_i;

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter ADR_W, default 8: address width, masters and slave.
REQ-002 SHALL have parameter DAT_W, default 8: data width, masters and slave.
REQ-003 SHALL have parameter TIMEOUT, default 16, legal range 2..31: wait cycles before bus-error termination.
REQ-004 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-low.
REQ-006 m0_cyc_i  in  1  master 0 bus request/cycle.
REQ-007 m0_stb_i  in  1  master 0 strobe.
REQ-008 m0_we_i  in  1  master 0 write enable.
REQ-009 m0_adr_i  in  ADR_W  master 0 address.
REQ-010 m0_dat_i  in  DAT_W  master 0 write data.
REQ-011 m0_ack_o  out  1  master 0 acknowledge.
REQ-012 m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_ack_o SHALL exist, identical to REQ-006..011, for master 1.
REQ-013 m_dat_o  out  DAT_W  read data, shared by both masters.
REQ-014 m_err_o  out  1  timeout termination flag, qualifies the ack of the current owner.
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1  slave-side cycle, strobe, write enable.
REQ-016 s_adr_o  out  ADR_W  slave address; s_dat_o  out  DAT_W  slave write data.
REQ-017 s_dat_i  in  DAT_W  slave read data; s_ack_i  in  1  slave acknowledge.
REQ-018 gnt_o  out  2  one-hot registered grant: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-019 SHALL implement FSM states IDLE, OWN0, OWN1, with gnt_o = 00/01/10 respectively.
REQ-020 SHALL hold a priority pointer: after an OWN0 tenure m1 is preferred; after an OWN1 tenure m0 is preferred.
REQ-021 IDLE: a cyc_i seen at edge N SHALL move the FSM to OWNx at edge N (one-cycle arbitration latency). Simultaneous requests SHALL go to the preferred master.
REQ-022 OWNx SHALL persist while mx_cyc_i=1; no preemption.
REQ-023 On owner cyc_i=0 at an edge, the FSM SHALL grant the other master directly if its cyc_i=1, else return to IDLE.
REQ-024 s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o SHALL combinationally mirror the owner's inputs. In IDLE, all slave outputs SHALL be 0.
REQ-025 mx_ack_o SHALL be s_ack_i & gnt_o[x] & mx_stb_i. The non-owner ack SHALL be 0. m_dat_o SHALL equal s_dat_i.
REQ-026 A 5-bit wait counter SHALL increment each cycle the owner has stb=1 and s_ack_i=0. It SHALL clear on ack, on stb=0, or on an ownership change.
REQ-027 When counter==TIMEOUT, the FSM SHALL, that cycle:
- assert owner ack and m_err_o=1;
- force m_dat_o to all-ones;
- force s_stb_o=0;
- clear the counter at the next edge.
REQ-028 m_err_o SHALL be 0 in every cycle except a timeout termination.
REQ-029 Pointer update SHALL happen only on tenure end; an uncontested re-request by the same master SHALL be granted.

Reset
REQ-030 With wb_rst_i=0 at an edge, the block SHALL go to IDLE, set gnt_o=00, clear the counter and point priority to m0. All slave outputs, acks and m_err_o SHALL therefore be 0.
REQ-031 Reset during an active transfer SHALL abort it immediately with no ack. First grant SHALL be possible one edge after wb_rst_i returns to 1.

Verification
REQ-032 m0 read of adr 0x02 alone, slave acks 1 cycle after stb with 0xA5 -> gnt_o=01, m0_ack_o pulse, m_dat_o=0xA5, m_err_o=0.
REQ-033 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; on m0 cyc drop, gnt_o goes 01->10 in one edge with no IDLE gap.
REQ-034 Both masters continuously requesting with 1-transfer tenures -> grants alternate 01,10,01,10.
REQ-035 Slave never acks, TIMEOUT=16 -> owner ack and m_err_o high in the 17th stb cycle, m_dat_o=0xFF, s_stb_o=0 that cycle.
REQ-036 wb_rst_i=0 mid m1 write with slave stalled -> next edge: gnt_o=00, s_cyc_o=0, no ack; after release an m1 request is granted.
REQ-037 m1 drops cyc while waiting (counter=5) -> counter clears, no ack, FSM to IDLE or OWN0 per REQ-023.
